// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: default widths and host FSM state encoding shared with the ALU side.
package alu_uart_pkg;
  localparam int NB_DATA_DEF   = 8;
  localparam int NB_OPCODE_DEF = 6;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT_RSP,
    ST_RESP
  } state_t;
endpackage

// File: rtl/alu_uart_host.sv
// alu_uart_host: sends opcode/A/B over the UART TX FIFO and returns the ALU result byte
// from the RX FIFO, or a timeout response if nothing arrives in time.
module alu_uart_host
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OPCODE      = NB_OPCODE_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [NB_OPCODE-1:0] i_cmd_opcode,
  input  logic [NB_DATA-1:0]   i_cmd_op_a,
  input  logic [NB_DATA-1:0]   i_cmd_op_b,
  output logic                 o_fifo_tx_write,
  output logic [NB_DATA-1:0]   o_data_to_write,
  input  logic                 i_fifo_tx_full,
  output logic                 o_fifo_rx_read,
  input  logic [NB_DATA-1:0]   i_data_to_read,
  input  logic                 i_fifo_rx_empty,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [NB_DATA-1:0]   o_rsp_data,
  output logic                 o_rsp_timeout,
  output logic                 o_busy
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t               state, state_nx;
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_DATA-1:0]   op_a, op_b;
  logic [CW-1:0]        cnt;
  logic                 accept, timeout_hit;
  // Ready is gated by reset so nothing can be handed over while the host is held in reset.
  assign o_cmd_ready     = i_reset_n && state == ST_IDLE;
  assign accept          = i_cmd_valid && o_cmd_ready;
  assign o_fifo_tx_write = state inside {ST_SEND_OP, ST_SEND_A, ST_SEND_B} && !i_fifo_tx_full;
  assign o_fifo_rx_read  = state == ST_WAIT_RSP && !i_fifo_rx_empty;
  assign timeout_hit     = TIMEOUT_CYCLES != 0 && state == ST_WAIT_RSP && i_fifo_rx_empty &&
                           cnt == CW'(TIMEOUT_CYCLES - 1);
  assign o_data_to_write = state == ST_SEND_OP ? NB_DATA'(opcode) :
                           state == ST_SEND_A  ? op_a :
                           state == ST_SEND_B  ? op_b : '0;
  assign o_rsp_valid     = state == ST_RESP;
  assign o_busy          = state != ST_IDLE;
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:     state_nx = accept ? ST_SEND_OP : ST_IDLE;
      ST_SEND_OP:  state_nx = o_fifo_tx_write ? ST_SEND_A : ST_SEND_OP;
      ST_SEND_A:   state_nx = o_fifo_tx_write ? ST_SEND_B : ST_SEND_A;
      ST_SEND_B:   state_nx = o_fifo_tx_write ? ST_WAIT_RSP : ST_SEND_B;
      ST_WAIT_RSP: state_nx = (o_fifo_rx_read || timeout_hit) ? ST_RESP : ST_WAIT_RSP;
      ST_RESP:     state_nx = i_rsp_ready ? ST_IDLE : ST_RESP;
      default:     state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      opcode        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      cnt           <= '0;
      o_rsp_data    <= '0;
      o_rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opcode <= i_cmd_opcode;
        op_a   <= i_cmd_op_a;
        op_b   <= i_cmd_op_b;
      end
      // Held at zero outside WAIT_RSP, so it is already clear on entry.
      if (state != ST_WAIT_RSP) cnt <= '0;
      else if (i_fifo_rx_empty) cnt <= cnt + 1'b1;
      if (o_fifo_rx_read) begin
        o_rsp_data    <= i_data_to_read;
        o_rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        o_rsp_data    <= '0;
        o_rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_uart_host.sv
// tb_alu_uart_host: randomized self-checking bench with a transaction-level FIFO/response model.
module tb_alu_uart_host;
  localparam int TO = 16;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cmd_valid, o_cmd_ready;
  logic [5:0] i_cmd_opcode;
  logic [7:0] i_cmd_op_a, i_cmd_op_b;
  logic       o_fifo_tx_write, i_fifo_tx_full;
  logic [7:0] o_data_to_write;
  logic       o_fifo_rx_read, i_fifo_rx_empty;
  logic [7:0] i_data_to_read;
  logic       o_rsp_valid, i_rsp_ready, o_rsp_timeout, o_busy;
  logic [7:0] o_rsp_data;
  logic [7:0] rx_q[$];
  int total = 0;
  int bad = 0;

  alu_uart_host #(.NB_DATA(8), .NB_OPCODE(6), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_opcode(i_cmd_opcode), .i_cmd_op_a(i_cmd_op_a), .i_cmd_op_b(i_cmd_op_b),
    .o_fifo_tx_write(o_fifo_tx_write), .o_data_to_write(o_data_to_write),
    .i_fifo_tx_full(i_fifo_tx_full),
    .o_fifo_rx_read(o_fifo_rx_read), .i_data_to_read(i_data_to_read),
    .i_fifo_rx_empty(i_fifo_rx_empty),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic drive_rx();
    i_fifo_rx_empty = rx_q.size() == 0;
    i_data_to_read  = 8'h00;
    if (rx_q.size() != 0) i_data_to_read = rx_q[0];
  endtask

  // One full transaction. rx_delay: cycles after the third byte is sent before the ALU
  // answer lands in the RX FIFO (negative: no answer). full_mode: 0 never, 1 cycles 2..4, 2 random.
  task automatic run_cmd(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int full_mode, input int rx_delay, input logic [7:0] rx_byte,
                         input int hold);
    logic [7:0] exp_b[3];
    logic [7:0] exp_data;
    logic       exp_to, exp_w, exp_r;
    int sent = 0, e = -1, c = 0, rsp_c = -1;
    bit done = 0;
    exp_b[0] = {2'b00, op};
    exp_b[1] = a;
    exp_b[2] = b;
    exp_data = 8'h00;
    exp_to   = 1'b0;
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_opcode = op; i_cmd_op_a = a; i_cmd_op_b = b;
    i_fifo_tx_full = 0; i_rsp_ready = 0;
    drive_rx();
    #1;
    total++;
    if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_idle got=%b exp=1", o_cmd_ready); end
    while (!done && c < 80) begin
      @(negedge clk);
      c++;
      i_cmd_valid = 0;
      i_fifo_tx_full = full_mode == 1 ? (c >= 2 && c <= 4) :
                       full_mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (e >= 0 && rx_delay >= 0 && c == e + rx_delay) rx_q.push_back(rx_byte);
      drive_rx();
      #1;
      total++;
      if (o_rsp_valid !== (rsp_c >= 0 && c >= rsp_c)) begin
        bad++; $display("FAIL rsp_valid_timing c=%0d got=%b exp=%b", c, o_rsp_valid, rsp_c >= 0 && c >= rsp_c);
      end
      if (rsp_c >= 0 && c >= rsp_c) begin
        done = 1;
        total++;
        if (o_rsp_data !== exp_data || o_rsp_timeout !== exp_to) begin
          bad++; $display("FAIL rsp_value got=%h/%b exp=%h/%b", o_rsp_data, o_rsp_timeout, exp_data, exp_to);
        end
      end
      total++;
      if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin
        bad++; $display("FAIL busy_ready c=%0d got=%b/%b exp=1/0", c, o_busy, o_cmd_ready);
      end
      exp_w = sent < 3 && !i_fifo_tx_full;
      total++;
      if (o_fifo_tx_write !== exp_w) begin
        bad++; $display("FAIL tx_write c=%0d got=%b exp=%b", c, o_fifo_tx_write, exp_w);
      end
      if (exp_w) begin
        total++;
        if (o_data_to_write !== exp_b[sent]) begin
          bad++; $display("FAIL tx_byte%0d got=%h exp=%h", sent, o_data_to_write, exp_b[sent]);
        end
        sent++;
        if (sent == 3) e = c + 1;
      end
      exp_r = e >= 0 && c >= e && rsp_c < 0 && rx_q.size() != 0;
      total++;
      if (o_fifo_rx_read !== exp_r) begin
        bad++; $display("FAIL rx_read c=%0d got=%b exp=%b", c, o_fifo_rx_read, exp_r);
      end
      if (exp_r) begin
        exp_data = rx_q.pop_front();
        exp_to = 0;
        rsp_c = c + 1;
      end else if (e >= 0 && rsp_c < 0 && c == e + TO - 1) begin
        exp_data = 8'h00;
        exp_to = 1;
        rsp_c = c + 1;
      end
    end
    if (!done) begin bad++; $display("FAIL rsp_never_valid after=%0d cycles exp=valid", c); end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      i_cmd_valid = 1; i_cmd_opcode = 6'($urandom); i_cmd_op_a = 8'($urandom); i_cmd_op_b = 8'($urandom);
      i_fifo_tx_full = 0; i_rsp_ready = 0;
      #1;
      total++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== exp_data || o_rsp_timeout !== exp_to ||
          o_cmd_ready !== 1'b0 || o_fifo_tx_write !== 1'b0) begin
        bad++; $display("FAIL rsp_hold k=%0d got=%b/%h/%b rdy=%b wr=%b exp=1/%h/%b rdy=0 wr=0",
                        k, o_rsp_valid, o_rsp_data, o_rsp_timeout, o_cmd_ready, o_fifo_tx_write, exp_data, exp_to);
      end
    end
    @(negedge clk);
    i_cmd_valid = 0; i_rsp_ready = 1; i_fifo_tx_full = 0;
    #1;
    total++;
    if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL rsp_handshake got=%b exp=1", o_rsp_valid); end
    @(negedge clk);
    i_rsp_ready = 0;
    #1;
    total++;
    if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1 || o_fifo_rx_read !== 1'b0) begin
      bad++; $display("FAIL back_to_idle got=v%b b%b r%b rd%b exp=v0 b0 r1 rd0",
                      o_rsp_valid, o_busy, o_cmd_ready, o_fifo_rx_read);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; i_cmd_valid = 1; i_cmd_opcode = 6'h3f; i_cmd_op_a = 8'hff; i_cmd_op_b = 8'hff;
    i_fifo_tx_full = 0; i_rsp_ready = 0;
    drive_rx();
    #2;
    total++;
    if ({o_cmd_ready, o_fifo_tx_write, o_fifo_rx_read, o_rsp_valid, o_rsp_timeout, o_busy} !== 6'b0 ||
        o_rsp_data !== 8'h00 || o_data_to_write !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%b data=%h wdata=%h exp=000000/00/00",
                      {o_cmd_ready, o_fifo_tx_write, o_fifo_rx_read, o_rsp_valid, o_rsp_timeout, o_busy},
                      o_rsp_data, o_data_to_write);
    end
    repeat (2) @(negedge clk);
    i_cmd_valid = 0;
    rst_n = 1;
    #1;
    total++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL reset_release got=%b/%b exp=1/0", o_cmd_ready, o_busy);
    end
  endtask

  task automatic test_basic();
    run_cmd(6'h20, 8'h05, 8'h03, 0, 0, 8'h08, 0);
  endtask

  task automatic test_tx_stall();
    run_cmd(6'h20, 8'h05, 8'h03, 1, 0, 8'h5a, 0);
  endtask

  task automatic test_timeout();
    run_cmd(6'h11, 8'h22, 8'h33, 0, -1, 8'h00, 1);
    run_cmd(6'h01, 8'h02, 8'h03, 0, TO - 1, 8'hc4, 0);
    run_cmd(6'h3f, 8'h80, 8'h7f, 0, TO, 8'h9e, 0);
    run_cmd(6'h0a, 8'h0b, 8'h0c, 0, -1, 8'h00, 0);
  endtask

  task automatic test_rsp_hold();
    run_cmd(6'h15, 8'hab, 8'hcd, 0, 2, 8'h77, 10);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_opcode = 6'h2c; i_cmd_op_a = 8'h44; i_cmd_op_b = 8'h55;
    i_fifo_tx_full = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      i_cmd_valid = 0;
      #1;
      total++;
      if (o_fifo_tx_write !== 1'b1) begin bad++; $display("FAIL mid_pre_write k=%0d got=%b exp=1", k, o_fifo_tx_write); end
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if (o_fifo_tx_write !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b0 || o_data_to_write !== 8'h00) begin
      bad++; $display("FAIL mid_reset got=wr%b busy%b rdy%b d%h exp=wr0 busy0 rdy0 d00",
                      o_fifo_tx_write, o_busy, o_cmd_ready, o_data_to_write);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (o_fifo_tx_write !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL mid_after_release k=%0d got=%b/%b exp=0/0", k, o_fifo_tx_write, o_busy);
      end
      @(negedge clk);
    end
    run_cmd(6'h2c, 8'h44, 8'h55, 0, 1, 8'h99, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int d;
      d = $urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(0, TO + 2));
      run_cmd(6'($urandom), 8'($urandom), 8'($urandom), 2, d, 8'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx_stall();
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_uart_host.md
ALU_UART_HOST -- requirements
Module: alu_uart_host

Interface
REQ-001 Parameter NB_DATA, default 8, data byte width.
REQ-002 Parameter NB_OPCODE, default 6, opcode width (NB_OPCODE <= NB_DATA).
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, response timeout in clock cycles; 0 disables timeout.
REQ-004 i_clk  in  1  single clock; all state on rising edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_cmd_valid  in  1  command request.
REQ-007 o_cmd_ready  out  1  command accepted when high together with i_cmd_valid.
REQ-008 i_cmd_opcode  in  NB_OPCODE  ALU opcode.
REQ-009 i_cmd_op_a / i_cmd_op_b  in  NB_DATA each  operands A, B.
REQ-010 o_fifo_tx_write  out  1  push strobe to TX FIFO.
REQ-011 o_data_to_write  out  NB_DATA  byte pushed.
REQ-012 i_fifo_tx_full  in  1  TX FIFO full.
REQ-013 o_fifo_rx_read  out  1  pop strobe to RX FIFO (first-word-fall-through).
REQ-014 i_data_to_read  in  NB_DATA  RX FIFO head byte, valid while not empty.
REQ-015 i_fifo_rx_empty  in  1  RX FIFO empty.
REQ-016 o_rsp_valid  out  1  response available; i_rsp_ready  in  1  response consumed.
REQ-017 o_rsp_data  out  NB_DATA  result byte; o_rsp_timeout  out  1  response is a timeout.
REQ-018 o_busy  out  1  high whenever state != IDLE.

Function
REQ-019 FSM states SHALL be IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RSP, RESP; unused encodings go to IDLE.
REQ-020 o_cmd_ready SHALL equal (state == IDLE); on i_cmd_valid & o_cmd_ready, opcode/A/B latched, next state SEND_OP.
REQ-021 In SEND_OP/SEND_A/SEND_B, o_fifo_tx_write SHALL equal ~i_fifo_tx_full (combinational); a byte transfers on each cycle the strobe is high, state advances SEND_OP->SEND_A->SEND_B->WAIT_RSP; if full, state holds, strobe low.
REQ-022 o_data_to_write SHALL be opcode zero-extended to NB_DATA in SEND_OP, A in SEND_A, B in SEND_B, zero elsewhere.
REQ-023 o_fifo_tx_write SHALL be 0 outside SEND_* states.
REQ-024 In WAIT_RSP, o_fifo_rx_read SHALL equal ~i_fifo_rx_empty; on the read cycle i_data_to_read captured into o_rsp_data, o_rsp_timeout cleared, next state RESP; o_fifo_rx_read 0 in every other state.
REQ-025 Timeout counter SHALL clear on entry to WAIT_RSP and increment each WAIT_RSP cycle with RX empty; when it reaches TIMEOUT_CYCLES-1 with RX still empty, next state RESP, o_rsp_data = 0, o_rsp_timeout = 1.
REQ-026 RX non-empty on the terminal timeout cycle SHALL take priority: data read, no timeout.
REQ-027 In RESP, o_rsp_valid = 1 with o_rsp_data/o_rsp_timeout stable until i_rsp_ready; then IDLE.
REQ-028 Minimum latency: command accepted cycle N, bytes written N+1, N+2, N+3, RX read N+4, o_rsp_valid high N+5.
REQ-029 No new command SHALL be accepted until the response handshake completes; RX bytes arriving outside WAIT_RSP are left in the FIFO.

Reset
REQ-030 i_reset_n low SHALL immediately force state IDLE, clear latched command, counter, o_rsp_data, o_rsp_timeout, o_rsp_valid; o_fifo_tx_write, o_fifo_rx_read, o_busy = 0; o_cmd_ready = 0 while reset asserted.
REQ-031 Reset mid-operation SHALL abandon the partial command; no further FIFO strobes for it after release.

Structure
REQ-032 Shared package alu_uart_pkg SHALL hold NB_DATA, NB_OPCODE defaults and the FSM state encoding, shared with the ALU-side interface.
REQ-033 No sub-module; FSM, command registers, and timeout counter live in this module.

Verification
REQ-034 Cmd opcode 6'h20, A 0x05, B 0x03, TX never full, RX supplies 0x08 at N+4 -> TX bytes 0x20, 0x05, 0x03 at N+1..N+3; o_rsp_valid at N+5, o_rsp_data 0x08, o_rsp_timeout 0.
REQ-035 i_fifo_tx_full high cycles N+2..N+4 -> A write stalls, bytes still 0x20, 0x05, 0x03 in order, no duplicate or lost byte.
REQ-036 TIMEOUT_CYCLES 16, RX stays empty -> o_rsp_valid with o_rsp_data 0x00, o_rsp_timeout 1, 16 cycles after WAIT_RSP entry; no RX read.
REQ-037 i_rsp_ready held low 10 cycles -> o_rsp_valid/o_rsp_data stable, o_cmd_ready 0, second i_cmd_valid ignored until handshake.
REQ-038 i_reset_n pulsed low after SEND_A -> strobes drop same cycle, o_busy 0; next command after release sends full 3-byte sequence.
